// File: rtl/uart_crc_tx_ctrl_pkg.sv
// Shared types and the CRC-8 helper for the UART CRC frame sequencer and its RX-side checker.
package uart_crc_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StCrcLoad,
    StCrcWait
  } state_e;

  localparam logic [7:0] Crc8PolyDefault = 8'h07;

  // MSB-first, non-reflected, one byte per call.
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data,
                                          input logic [7:0] poly);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ data[7-i]) ? poly : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_crc_tx_ctrl_if.sv
// Byte-stream input and UART_TX control signals of the frame sequencer.
interface uart_crc_tx_ctrl_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;
  logic [7:0] utx_data_o;
  logic       utx_we_o;
  logic       utx_en_o;
  logic       utx_done_i;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, utx_done_i,
    output s_ready_o, utx_data_o, utx_we_o, utx_en_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, utx_done_i,
    input  s_ready_o, utx_data_o, utx_we_o, utx_en_o
  );
endinterface

// File: rtl/uart_crc_tx_ctrl_crc8_byte.sv
// Combinational byte-wide CRC-8 update; shared with the RX-side checker.
module uart_crc_tx_ctrl_crc8_byte
  import uart_crc_tx_ctrl_pkg::*;
#(
  parameter logic [7:0] POLY = Crc8PolyDefault
) (
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  assign crc_o = crc8_upd(crc_i, data_i, POLY);

endmodule

// File: rtl/uart_crc_tx_ctrl.sv
// Frame sequencer for UART_TX: loads each payload byte, waits for its completion and appends a
// CRC-8 byte after the last one, with a per-byte timeout and an overlength cut-off.
module uart_crc_tx_ctrl
  import uart_crc_tx_ctrl_pkg::*;
#(
  parameter logic [7:0]  CRC_POLY    = Crc8PolyDefault,
  parameter logic [7:0]  CRC_INIT    = 8'h00,
  parameter int unsigned MAX_LEN     = 255,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic               clk_master,
  input  logic               rst_i,
  uart_crc_tx_ctrl_if.slave  bus,
  output logic               busy_o,
  output logic               frame_done_o,
  output logic               frame_err_o,
  output logic [7:0]         crc_o,
  output logic [7:0]         byte_cnt_o
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MaxLen  = 8'(MAX_LEN);

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic            ovl_q, ovl_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            done_q;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [7:0]      crc_out_q, crc_out_d;
  logic            fdone_q, fdone_d;
  logic            ferr_q, ferr_d;

  logic [7:0] crc_base, crc_upd, cnt_inc;
  logic       done_edge, tmo_hit, at_max;

  // Outside a frame the CRC and byte count restart from their initial values.
  assign crc_base  = busy_q ? crc_q : CRC_INIT;
  assign cnt_inc   = (busy_q ? cnt_q : 8'd0) + 8'd1;
  assign at_max    = (cnt_inc == MaxLen);
  assign done_edge = bus.utx_done_i & ~done_q;
  assign tmo_hit   = (tmo_q == TmoLast);

  uart_crc_tx_ctrl_crc8_byte #(
    .POLY (CRC_POLY)
  ) u_crc (
    .crc_i  (crc_base),
    .data_i (bus.s_data_i),
    .crc_o  (crc_upd)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    ovl_d     = ovl_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    en_d      = en_q;
    busy_d    = busy_q;
    crc_out_d = crc_out_q;
    fdone_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.s_valid_i) begin
          data_d  = bus.s_data_i;
          crc_d   = crc_upd;
          cnt_d   = cnt_inc;
          last_d  = bus.s_last_i | at_max;
          ovl_d   = ~bus.s_last_i & at_max;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (done_edge) begin
          if (last_q) begin
            data_d  = crc_q;
            state_d = StCrcLoad;
          end else begin
            state_d = StIdle;
          end
        end else if (tmo_hit) begin
          ferr_d  = 1'b1;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StCrcLoad: begin
        tmo_d   = '0;
        state_d = StCrcWait;
      end
      StCrcWait: begin
        tmo_d = tmo_q + 1'b1;
        if (done_edge) begin
          crc_out_d = crc_q;
          fdone_d   = 1'b1;
          ferr_d    = ovl_q;
          en_d      = 1'b0;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end else if (tmo_hit) begin
          ferr_d  = 1'b1;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_master or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      ovl_q     <= 1'b0;
      crc_q     <= CRC_INIT;
      cnt_q     <= 8'h00;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      crc_out_q <= 8'h00;
      fdone_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      last_q    <= last_d;
      ovl_q     <= ovl_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      done_q    <= bus.utx_done_i;
      en_q      <= en_d;
      busy_q    <= busy_d;
      crc_out_q <= crc_out_d;
      fdone_q   <= fdone_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.s_ready_o  = (state_q == StIdle);
  assign bus.utx_we_o   = (state_q == StLoad) || (state_q == StCrcLoad);
  assign bus.utx_data_o = data_q;
  assign bus.utx_en_o   = en_q;
  assign busy_o         = busy_q;
  assign frame_done_o   = fdone_q;
  assign frame_err_o    = ferr_q;
  assign crc_o          = crc_out_q;
  assign byte_cnt_o     = cnt_q;

endmodule

// File: tb/tb_uart_crc_tx_ctrl.sv
// Randomised self-checking bench for uart_crc_tx_ctrl with a behavioural UART_TX stand-in.
module tb_uart_crc_tx_ctrl;

  localparam int unsigned TmoCyc = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_crc_tx_ctrl_if u ();
  uart_crc_tx_ctrl_if u2 ();

  logic       busy, fdone, ferr, busy2, fdone2, ferr2;
  logic [7:0] crc, bcnt, crc2, bcnt2;

  uart_crc_tx_ctrl #(
    .CRC_POLY(8'h07), .CRC_INIT(8'h00), .MAX_LEN(255), .TIMEOUT_CYC(TmoCyc)
  ) dut (
    .clk_master(clk), .rst_i(rst), .bus(u.slave), .busy_o(busy), .frame_done_o(fdone),
    .frame_err_o(ferr), .crc_o(crc), .byte_cnt_o(bcnt)
  );

  uart_crc_tx_ctrl #(
    .CRC_POLY(8'h07), .CRC_INIT(8'h00), .MAX_LEN(4), .TIMEOUT_CYC(TmoCyc)
  ) dut2 (
    .clk_master(clk), .rst_i(rst), .bus(u2.slave), .busy_o(busy2), .frame_done_o(fdone2),
    .frame_err_o(ferr2), .crc_o(crc2), .byte_cnt_o(bcnt2)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] tx2_q[$];
  logic [7:0] crc_log[$];
  int done_n = 0, err_n = 0, done2_n = 0, err2_n = 0, both2_n = 0;
  int we_ready_bad = 0, we_dbl_bad = 0, en_done_bad = 0;
  longint cyc = 0, last_we_cyc = 0, err_cyc = 0;
  logic prev_we = 1'b0;
  bit resp_en = 1'b1;
  int dly = 0, dly2 = 0;

  // Reference CRC: remainder of M(x)*x^8 divided by x^8+x^2+x+1, by plain long division.
  function automatic logic [7:0] ref_crc(input logic [7:0] m[$]);
    logic [8:0] rem;
    int nb;
    bit b;
    rem = 9'h000;
    nb = m.size() * 8;
    for (int k = 0; k < nb + 8; k++) begin
      b = (k < nb) ? m[k/8][7-(k%8)] : 1'b0;
      rem = {rem[7:0], b};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  // UART_TX stand-ins: one-cycle tx_done pulse a few cycles after each load strobe.
  always @(negedge clk) begin
    if (rst) begin
      u.utx_done_i = 1'b0;
      dly = 0;
    end else begin
      u.utx_done_i = 1'b0;
      if (u.utx_we_o) dly = $urandom_range(6, 2);
      else if (dly > 0) begin
        dly--;
        if (dly == 0 && resp_en) u.utx_done_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      u2.utx_done_i = 1'b0;
      dly2 = 0;
    end else begin
      u2.utx_done_i = 1'b0;
      if (u2.utx_we_o) dly2 = $urandom_range(6, 2);
      else if (dly2 > 0) begin
        dly2--;
        if (dly2 == 0) u2.utx_done_i = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (u.utx_we_o) begin
        tx_q.push_back(u.utx_data_o);
        last_we_cyc = cyc;
        if (u.s_ready_o) we_ready_bad++;
        if (prev_we) we_dbl_bad++;
      end
      if (fdone) begin
        done_n++;
        crc_log.push_back(crc);
        if (u.utx_en_o) en_done_bad++;
      end
      if (ferr) begin
        err_n++;
        err_cyc = cyc;
      end
      prev_we = u.utx_we_o;
      if (u2.utx_we_o) tx2_q.push_back(u2.utx_data_o);
      if (fdone2) done2_n++;
      if (ferr2) err2_n++;
      if (fdone2 && ferr2) both2_n++;
    end
  end

  task automatic send_frame(input logic [7:0] b[$], input bit l[$], input int unsigned gap_max,
                            output bit ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < b.size(); i++) begin
      u.s_valid_i = 1'b1;
      u.s_data_i  = b[i];
      u.s_last_i  = l[i];
      n = 0;
      while (!u.s_ready_o && n < 20000) begin
        @(negedge clk);
        n++;
      end
      if (!u.s_ready_o) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      if (gap_max > 0) begin
        u.s_valid_i = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
    end
    u.s_valid_i = 1'b0;
    u.s_last_i  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    #1;
    ok = !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, fdone, ferr, u.utx_we_o, u.utx_en_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, fdone, ferr, u.utx_we_o, u.utx_en_o});
    end
    n_chk++;
    if ({crc, bcnt, u.utx_data_o} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_values: got crc=%h cnt=%h data=%h expected 0", crc, bcnt, u.utx_data_o);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (u.s_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", u.s_ready_o);
    end
  endtask

  task automatic test_single();
    logic [7:0] b[$];
    bit l[$];
    bit ok;
    int d0;
    d0 = done_n;
    tx_q.delete();
    b = '{8'hDA};
    l = '{1'b1};
    send_frame(b, l, 0, ok);
    wait_idle(ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b expected 0", busy);
    end
    n_chk++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hDA || tx_q[1] !== 8'h08) begin
      n_fail++;
      $display("FAIL single_tx: got %0d bytes %p expected DA 08", tx_q.size(), tx_q);
    end
    n_chk++;
    if (crc !== 8'h08 || bcnt !== 8'd1) begin
      n_fail++;
      $display("FAIL single_crc: got crc=%h cnt=%0d expected crc=08 cnt=1", crc, bcnt);
    end
    n_chk++;
    if (done_n - d0 != 1 || u.utx_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got %0d pulses en=%b expected 1 pulse en=0", done_n - d0,
               u.utx_en_o);
    end
  endtask

  task automatic test_check_string();
    logic [7:0] b[$];
    bit l[$];
    bit ok;
    int bad;
    tx_q.delete();
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    l = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    send_frame(b, l, 2, ok);
    wait_idle(ok);
    bad = (tx_q.size() != 10) ? 1 : 0;
    for (int i = 0; i < 9 && bad == 0; i++) if (tx_q[i] !== b[i]) bad = 1;
    if (bad == 0 && tx_q[9] !== 8'hF4) bad = 1;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL check_string_tx: got %p expected 31..39 F4", tx_q);
    end
    n_chk++;
    if (crc !== 8'hF4 || bcnt !== 8'd9) begin
      n_fail++;
      $display("FAIL check_string_crc: got crc=%h cnt=%0d expected F4 9", crc, bcnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    logic [7:0] c2[$];
    bit l[$];
    bit ok;
    int c0, e0;
    tx_q.delete();
    c0 = crc_log.size();
    e0 = en_done_bad;
    b = '{8'hDA, 8'h2D};
    l = '{1'b1, 1'b1};
    c2 = '{8'h2D};
    send_frame(b, l, 0, ok);
    wait_idle(ok);
    n_chk++;
    if (crc_log.size() != c0 + 2 || crc_log[c0] !== 8'h08 || crc_log[c0+1] !== ref_crc(c2)) begin
      n_fail++;
      $display("FAIL b2b_crc: got %p expected 08 then %h", crc_log, ref_crc(c2));
    end
    n_chk++;
    if (tx_q.size() != 4 || tx_q[2] !== 8'h2D || tx_q[3] !== ref_crc(c2)) begin
      n_fail++;
      $display("FAIL b2b_tx: got %p expected DA 08 2D %h", tx_q, ref_crc(c2));
    end
    n_chk++;
    if (en_done_bad != e0) begin
      n_fail++;
      $display("FAIL b2b_en_drop: got %0d frames with en high at done expected 0",
               en_done_bad - e0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    logic [7:0] exp[$];
    bit l[$];
    bit ok;
    int len, bad;
    for (int f = 0; f < 6; f++) begin
      tx_q.delete();
      b.delete();
      l.delete();
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        b.push_back(8'($urandom));
        l.push_back(i == len - 1);
      end
      exp = b;
      exp.push_back(ref_crc(b));
      send_frame(b, l, 3, ok);
      wait_idle(ok);
      bad = (tx_q.size() != exp.size()) ? 1 : 0;
      for (int i = 0; i < exp.size() && bad == 0; i++) if (tx_q[i] !== exp[i]) bad = 1;
      n_chk++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_tx[%0d]: got %p expected %p", f, tx_q, exp);
      end
      n_chk++;
      if (crc !== ref_crc(b) || bcnt !== 8'(len)) begin
        n_fail++;
        $display("FAIL random_crc[%0d]: got crc=%h cnt=%0d expected crc=%h cnt=%0d", f, crc, bcnt,
                 ref_crc(b), len);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b[$];
    bit l[$];
    bit ok;
    logic [7:0] prev_crc;
    int d0, e0, n;
    longint el;
    prev_crc = crc;
    d0 = done_n;
    e0 = err_n;
    resp_en = 1'b0;
    b = '{8'h5A};
    l = '{1'b0};
    send_frame(b, l, 0, ok);
    n = 0;
    while (err_n == e0 && n < TmoCyc + 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    el = err_cyc - last_we_cyc;
    n_chk++;
    if (err_n - e0 != 1 || el < TmoCyc || el > TmoCyc + 2) begin
      n_fail++;
      $display("FAIL timeout_err: got %0d pulses after %0d cycles expected 1 after ~%0d",
               err_n - e0, el, TmoCyc);
    end
    n_chk++;
    if (busy !== 1'b0 || u.utx_en_o !== 1'b0 || crc !== prev_crc || done_n != d0) begin
      n_fail++;
      $display("FAIL timeout_state: got busy=%b en=%b crc=%h done=%0d expected 0 0 %h 0", busy,
               u.utx_en_o, crc, done_n - d0, prev_crc);
    end
    resp_en = 1'b1;
    repeat (10) @(negedge clk);
    b = '{8'hDA};
    l = '{1'b1};
    send_frame(b, l, 0, ok);
    wait_idle(ok);
    n_chk++;
    if (crc !== 8'h08 || bcnt !== 8'd1) begin
      n_fail++;
      $display("FAIL timeout_recover: got crc=%h cnt=%0d expected 08 1", crc, bcnt);
    end
  endtask

  task automatic test_overlength();
    logic [7:0] ob[$];
    logic [7:0] hd[$];
    int n, bad;
    for (int i = 0; i < 5; i++) ob.push_back(8'($urandom));
    hd = ob[0:3];
    tx2_q.delete();
    for (int i = 0; i < 5; i++) begin
      u2.s_valid_i = 1'b1;
      u2.s_data_i  = ob[i];
      u2.s_last_i  = 1'b0;
      n = 0;
      while (!u2.s_ready_o && n < 200) begin
        @(negedge clk);
        n++;
      end
      n_chk++;
      if (!u2.s_ready_o) begin
        n_fail++;
        $display("FAIL ovl_accept[%0d]: got ready=0 expected 1 within 200 cycles", i);
      end
      @(negedge clk);
    end
    u2.s_valid_i = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    bad = (tx2_q.size() != 6) ? 1 : 0;
    for (int i = 0; i < 4 && bad == 0; i++) if (tx2_q[i] !== ob[i]) bad = 1;
    if (bad == 0 && (tx2_q[4] !== ref_crc(hd) || tx2_q[5] !== ob[4])) bad = 1;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ovl_tx: got %p expected %p then crc %h then %h", tx2_q, hd, ref_crc(hd),
               ob[4]);
    end
    n_chk++;
    if (both2_n != 1 || done2_n != 1 || err2_n != 1) begin
      n_fail++;
      $display("FAIL ovl_pulses: got both=%0d done=%0d err=%0d expected 1 1 1", both2_n, done2_n,
               err2_n);
    end
    n_chk++;
    if (crc2 !== ref_crc(hd) || bcnt2 !== 8'd1 || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovl_state: got crc=%h cnt=%0d busy=%b expected %h 1 1", crc2, bcnt2, busy2,
               ref_crc(hd));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    bit l[$];
    bit ok;
    tx_q.delete();
    b = '{8'h11, 8'h22};
    l = '{1'b0, 1'b0};
    send_frame(b, l, 0, ok);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, fdone, ferr, u.utx_we_o, u.utx_en_o} !== 5'b0 || bcnt !== 8'h00 ||
        crc !== 8'h00 || u.utx_data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: got flags=%b cnt=%h crc=%h data=%h expected all 0",
               {busy, fdone, ferr, u.utx_we_o, u.utx_en_o}, bcnt, crc, u.utx_data_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_q.delete();
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    l = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    send_frame(b, l, 0, ok);
    wait_idle(ok);
    n_chk++;
    if (tx_q.size() != 10 || crc !== 8'hF4 || bcnt !== 8'd9) begin
      n_fail++;
      $display("FAIL reset_mid_clean: got %0d bytes crc=%h cnt=%0d expected 10 F4 9", tx_q.size(),
               crc, bcnt);
    end
  endtask

  initial begin
    u.s_valid_i  = 1'b0;
    u.s_last_i   = 1'b0;
    u.s_data_i   = 8'h00;
    u2.s_valid_i = 1'b0;
    u2.s_last_i  = 1'b0;
    u2.s_data_i  = 8'h00;
    test_reset();
    test_single();
    test_check_string();
    test_back_to_back();
    test_random();
    test_timeout();
    test_overlength();
    test_reset_mid();
    n_chk++;
    if (we_ready_bad != 0 || we_dbl_bad != 0) begin
      n_fail++;
      $display("FAIL strobe_rules: got ready_during_we=%0d long_we=%0d expected 0 0", we_ready_bad,
               we_dbl_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
